// File: rtl/operate_scheduler.sv
// operate_scheduler
// Arbitrates manual and script operate requests round-robin, checks each
// command against player/target status and per-machine item counts, sends
// the operate code to the transmitter and waits for the game's feedback.
// Item counts change only when the game confirms a command.
// Optional build macro: OPERATE_RETRY_EN -- resend the same command up to
// two more times on negative feedback or timeout before reporting an error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; grants one and latches op/target
// S_CHECK | one-cycle legality check (reject / ignore / go send)
// S_SEND  | TxValid high, TxData held until TxReady is seen
// S_WAIT  | waiting for game feedback, timeout down-counter running
module operate_scheduler #(
  parameter int MAX_ITEM_NUM   = 3,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ManualValid,
  output logic       ManualReady,
  input  logic [7:0] ManualOperate,
  input  logic [4:0] ManualTarget,
  input  logic       ScriptValid,
  output logic       ScriptReady,
  input  logic [7:0] ScriptOperate,
  input  logic [4:0] ScriptTarget,
  input  logic       InFrontOfTarget,
  input  logic       HasItemInHand,
  input  logic       TargetHasItem,
  output logic       TxValid,
  input  logic       TxReady,
  output logic [7:0] TxData,
  input  logic       FeedbackValid,
  input  logic       FeedbackOk,
  output logic       Busy,
  output logic       DonePulse,
  output logic       RejectPulse,
  output logic       ErrorPulse,
  input  logic [4:0] QueryAddr,
  output logic [3:0] QueryCount
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SEND, S_WAIT} state_t;

  localparam logic [3:0]       MAX_C    = 4'(MAX_ITEM_NUM);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       WB_SLOT  = 3'd5;
  localparam logic [2:0]       NO_SLOT  = 3'd7;

  // Only tables (slots 0..4) and the workbench (slot 5) keep a count.
  function automatic logic [2:0] slot_of(input logic [4:0] t);
    case (t)
      5'd9:    slot_of = 3'd0;
      5'd11:   slot_of = 3'd1;
      5'd14:   slot_of = 3'd2;
      5'd17:   slot_of = 3'd3;
      5'd19:   slot_of = 3'd4;
      5'd15:   slot_of = WB_SLOT;
      default: slot_of = NO_SLOT;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             rr_q, rr_d;      // 1: script has priority on a tie
  logic [7:0]       op_q, op_d;
  logic [4:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [3:0]       cnt_q [6];
  logic [3:0]       cnt_d [6];
`ifdef OPERATE_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic [4:0] kind;
  logic       is_get, is_put, is_interact, is_move, is_throw, is_ignore;
  logic       kind_ok, tgt_bad, is_crate, is_mill;
  logic [2:0] cur_slot, q_slot;
  logic       cur_table, cur_wb;
  logic [3:0] cur_cnt;
  logic       illegal, fail;

  assign kind        = op_q[6:2];
  assign is_get      = (kind == 5'b00001);
  assign is_put      = (kind == 5'b00010);
  assign is_interact = (kind == 5'b00100);
  assign is_move     = (kind == 5'b01000);
  assign is_throw    = (kind == 5'b10000);
  assign is_ignore   = (kind == 5'b00000);
  assign kind_ok     = is_get | is_put | is_interact | is_move | is_throw;

  assign tgt_bad  = (tgt_q == 5'd0) || (tgt_q > 5'd20);
  assign is_crate = (tgt_q >= 5'd1) && (tgt_q <= 5'd6);
  assign is_mill  = (tgt_q == 5'd7) || (tgt_q == 5'd8);

  assign cur_slot  = slot_of(tgt_q);
  assign cur_table = (cur_slot < WB_SLOT);
  assign cur_wb    = (cur_slot == WB_SLOT);
  assign cur_cnt   = (cur_slot != NO_SLOT) ? cnt_q[cur_slot] : 4'd0;

  assign q_slot     = slot_of(QueryAddr);
  assign QueryCount = (q_slot != NO_SLOT) ? cnt_q[q_slot] : 4'd0;

  assign TxData = op_q;
  assign Busy   = (state_q != S_IDLE);

  // Legality of the latched command against live status and counts.
  always_comb begin
    illegal = 1'b0;
    if (!kind_ok)                                 illegal = 1'b1;
    if (!is_move && !InFrontOfTarget)             illegal = 1'b1;
    if (is_put && !HasItemInHand)                 illegal = 1'b1;
    if (is_get && (HasItemInHand || !TargetHasItem)) illegal = 1'b1;
    if (!is_move && tgt_bad)                      illegal = 1'b1;
    if (is_crate && (is_put || is_throw))         illegal = 1'b1;
    if (is_mill && is_throw)                      illegal = 1'b1;
    if (cur_table && ((is_get && cur_cnt == 4'd0) ||
                      ((is_put || is_throw) && cur_cnt >= MAX_C)))
      illegal = 1'b1;
    if (cur_wb && ((is_get && cur_cnt == 4'd0) || (is_put && cur_cnt >= MAX_C)))
      illegal = 1'b1;
  end

  // Next-state, grant, commit and pulse outputs.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    tmr_d   = tmr_q;
    for (int i = 0; i < 6; i++) cnt_d[i] = cnt_q[i];
`ifdef OPERATE_RETRY_EN
    retry_d = retry_q;
`endif
    ManualReady = 1'b0;
    ScriptReady = 1'b0;
    TxValid     = 1'b0;
    DonePulse   = 1'b0;
    RejectPulse = 1'b0;
    ErrorPulse  = 1'b0;
    fail        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ManualValid && (!ScriptValid || !rr_q)) begin
          ManualReady = 1'b1;
          op_d        = ManualOperate;
          tgt_d       = ManualTarget;
          rr_d        = 1'b1;
          state_d     = S_CHECK;
`ifdef OPERATE_RETRY_EN
          retry_d     = 2'd0;
`endif
        end else if (ScriptValid) begin
          ScriptReady = 1'b1;
          op_d        = ScriptOperate;
          tgt_d       = ScriptTarget;
          rr_d        = 1'b0;
          state_d     = S_CHECK;
`ifdef OPERATE_RETRY_EN
          retry_d     = 2'd0;
`endif
        end
      end
      S_CHECK: begin
        if (is_ignore) begin
          DonePulse = 1'b1;
          state_d   = S_IDLE;
        end else if (illegal) begin
          RejectPulse = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        TxValid = 1'b1;
        if (TxReady) begin
          tmr_d   = TMO_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (FeedbackValid) begin
          if (FeedbackOk) begin
            if (cur_slot != NO_SLOT) begin
              if (is_get && cur_cnt != 4'd0)
                cnt_d[cur_slot] = cur_cnt - 4'd1;
              else if ((is_put || (is_throw && cur_table)) && cur_cnt < MAX_C)
                cnt_d[cur_slot] = cur_cnt + 4'd1;
            end
            DonePulse = 1'b1;
            state_d   = S_IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (tmr_q == '0) begin
          fail = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
        if (fail) begin
`ifdef OPERATE_RETRY_EN
          if (retry_q != 2'd2) begin
            retry_d = retry_q + 2'd1;
            state_d = S_SEND;
          end else begin
            ErrorPulse = 1'b1;
            state_d    = S_IDLE;
          end
`else
          ErrorPulse = 1'b1;
          state_d    = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched command, timer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      op_q    <= 8'b0000_0010;
      tgt_q   <= '0;
      tmr_q   <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
`ifdef OPERATE_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
`ifdef OPERATE_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_operate_scheduler.sv
// Directed bench for operate_scheduler (short timeout for run time).
module tb_operate_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ManualValid = 1'b0, ScriptValid = 1'b0;
  logic       ManualReady, ScriptReady;
  logic [7:0] ManualOperate = 8'h00, ScriptOperate = 8'h00;
  logic [4:0] ManualTarget = 5'd0, ScriptTarget = 5'd0;
  logic       InFrontOfTarget = 1'b1, HasItemInHand = 1'b1, TargetHasItem = 1'b0;
  logic       TxValid, TxReady = 1'b1;
  logic [7:0] TxData;
  logic       FeedbackValid = 1'b0, FeedbackOk = 1'b0;
  logic       Busy, DonePulse, RejectPulse, ErrorPulse;
  logic [4:0] QueryAddr = 5'd0;
  logic [3:0] QueryCount;

  operate_scheduler #(.MAX_ITEM_NUM(3), .TIMEOUT_CYCLES(20), .CNT_W(20)) dut (
    .clk(clk), .rst(rst),
    .ManualValid(ManualValid), .ManualReady(ManualReady),
    .ManualOperate(ManualOperate), .ManualTarget(ManualTarget),
    .ScriptValid(ScriptValid), .ScriptReady(ScriptReady),
    .ScriptOperate(ScriptOperate), .ScriptTarget(ScriptTarget),
    .InFrontOfTarget(InFrontOfTarget), .HasItemInHand(HasItemInHand),
    .TargetHasItem(TargetHasItem),
    .TxValid(TxValid), .TxReady(TxReady), .TxData(TxData),
    .FeedbackValid(FeedbackValid), .FeedbackOk(FeedbackOk),
    .Busy(Busy), .DonePulse(DonePulse), .RejectPulse(RejectPulse),
    .ErrorPulse(ErrorPulse), .QueryAddr(QueryAddr), .QueryCount(QueryCount)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, check its Ready, leave the DUT in CHECK.
  task automatic accept(input bit scr, input logic [7:0] op, input logic [4:0] tgt);
    if (scr) begin
      ScriptValid = 1'b1; ScriptOperate = op; ScriptTarget = tgt;
    end else begin
      ManualValid = 1'b1; ManualOperate = op; ManualTarget = tgt;
    end
    #1;
    if (scr) chk("script_ready", ScriptReady, 1);
    else     chk("manual_ready", ManualReady, 1);
    tick();
    ManualValid = 1'b0;
    ScriptValid = 1'b0;
  endtask

  task automatic expect_reject(input string tag);
    #1;
    chk({tag, "_reject"}, RejectPulse, 1);
    chk({tag, "_no_tx"}, TxValid, 0);
    tick();
    #1 chk({tag, "_idle"}, Busy, 0);
  endtask

  // From CHECK: legal, transmitted two cycles after grant, acked OK.
  task automatic send_ack(input string tag, input logic [7:0] op);
    #1 chk({tag, "_legal"}, RejectPulse, 0);
    tick();
    TxReady = 1'b1;
    #1;
    chk({tag, "_txvalid"}, TxValid, 1);
    chk({tag, "_txdata"}, TxData, op);
    tick();
    FeedbackValid = 1'b1; FeedbackOk = 1'b1;
    #1 chk({tag, "_done"}, DonePulse, 1);
    tick();
    FeedbackValid = 1'b0; FeedbackOk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    QueryAddr = 5'd9;
    tick(); tick();
    chk("rst_txdata", TxData, 8'h02);
    chk("rst_txvalid", TxValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_pulses", {ManualReady, ScriptReady, DonePulse, RejectPulse, ErrorPulse}, 0);
    chk("rst_count9", QueryCount, 0);
    rst = 1'b0;
    tick();

    // PUT to table 9, acked
    accept(0, 8'h0A, 5'd9);
    #1 chk("t1_check_no_tx", TxValid, 0);
    send_ack("t1", 8'h0A);
    QueryAddr = 5'd9;
    #1 chk("t1_count9", QueryCount, 1);

    // four PUTs to table 11: fourth rejected at MAX
    for (int i = 0; i < 3; i++) begin
      accept(0, 8'h0A, 5'd11);
      send_ack("t2", 8'h0A);
    end
    QueryAddr = 5'd11;
    #1 chk("t2_count11_full", QueryCount, 3);
    accept(0, 8'h0A, 5'd11);
    expect_reject("t2_fourth");
    #1 chk("t2_count11_after", QueryCount, 3);

    // reset, then both requesters valid continuously (IGNORE ops)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    #1 chk("t3_count11_cleared", QueryCount, 0);
    ManualValid = 1'b1; ManualOperate = 8'h02; ManualTarget = 5'd9;
    ScriptValid = 1'b1; ScriptOperate = 8'h82; ScriptTarget = 5'd9;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_manual_ready", ManualReady, (i % 4 == 0) ? 1 : 0);
      chk("t3_script_ready", ScriptReady, (i % 4 == 2) ? 1 : 0);
      chk("t3_ignore_done", DonePulse, (i % 2 == 1) ? 1 : 0);
      chk("t3_no_tx", TxValid, 0);
      tick();
    end
    ManualValid = 1'b0; ScriptValid = 1'b0;

    // legality checks
    InFrontOfTarget = 1'b1; HasItemInHand = 1'b1; TargetHasItem = 1'b1;
    accept(0, 8'h42, 5'd3);
    expect_reject("t4_throw_crate");
    accept(0, 8'h06, 5'd20);
    expect_reject("t4_get_holding");
    HasItemInHand = 1'b0;
    accept(0, 8'h06, 5'd20);
    send_ack("t4_get_ok", 8'h06);
    accept(0, 8'h06, 5'd9);
    expect_reject("t4_get_table_empty");
    accept(0, 8'h0E, 5'd9);
    expect_reject("t4_not_onehot");
    HasItemInHand = 1'b1;
    accept(0, 8'h0A, 5'd21);
    expect_reject("t4_target_21");
    InFrontOfTarget = 1'b0;
    accept(0, 8'hA2, 5'd0);
    send_ack("t4_move", 8'hA2);
    InFrontOfTarget = 1'b1;

    // PUT to workbench 15 with no feedback: timeout
    accept(0, 8'h0A, 5'd15);
    #1 chk("t5_legal", RejectPulse, 0);
    tick();
    TxReady = 1'b1;
    #1 chk("t5_txvalid", TxValid, 1);
    tick();
    for (int k = 1; k <= 20; k++) begin
      #1 chk("t5_error", ErrorPulse, (k == 20) ? 1 : 0);
      tick();
    end
    FeedbackValid = 1'b1; FeedbackOk = 1'b1;
    #1;
    chk("t5_late_fb_done", DonePulse, 0);
    chk("t5_idle", Busy, 0);
    tick();
    FeedbackValid = 1'b0; FeedbackOk = 1'b0;
    QueryAddr = 5'd15;
    #1 chk("t5_count15", QueryCount, 0);

    // table 17 PUT, then stall in SEND and reset during WAIT_ACK
    accept(0, 8'h0A, 5'd17);
    send_ack("t6_t17", 8'h0A);
    QueryAddr = 5'd17;
    #1 chk("t6_count17", QueryCount, 1);
    TxReady = 1'b0;
    accept(0, 8'h0A, 5'd14);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_hold_valid", TxValid, 1);
      chk("t6_hold_data", TxData, 8'h0A);
      tick();
    end
    TxReady = 1'b1;
    #1 chk("t6_release_valid", TxValid, 1);
    tick();
    #1;
    chk("t6_wait_txvalid", TxValid, 0);
    chk("t6_wait_busy", Busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", Busy, 0);
    chk("t6_rst_txdata", TxData, 8'h02);
    FeedbackValid = 1'b1; FeedbackOk = 1'b1;
    #1 chk("t6_rst_done", DonePulse, 0);
    tick(); tick();
    rst = 1'b0;
    FeedbackValid = 1'b0; FeedbackOk = 1'b0;
    tick();
    #1 chk("t6_count17_cleared", QueryCount, 0);
    QueryAddr = 5'd14;
    #1 chk("t6_count14", QueryCount, 0);
    QueryAddr = 5'd25;
    #1 chk("t6_query_oob", QueryCount, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
